hcs_scan_controller: RTL and testbench



---
 rtl/hcs_scan_controller.sv | 153 +++++++++++++++
 tb/tb_hcs_scan_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hcs_scan_controller.sv
// hcs_scan_controller: sequences the four healthCareSystem monitor channels
// (pressure, blood, fall, temperature). For each channel it requests a sample,
// waits for the ack, lets the inputs settle, then debounces the channel's
// abnormality flag into a registered alarm bit.
// Optional build macro: FALL_LATCH_EN makes alarm[2] sticky until fallClear.
module hcs_scan_controller #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ALARM_COUNT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scanEnable,
  output logic [1:0] sensorSel,
  output logic       sensorReq,
  input  logic       sensorAck,
  input  logic       presureAbnormality,
  input  logic       bloodAbnormality,
  input  logic       fallDetected,
  input  logic       temperatureAbnormality,
  input  logic [3:0] glycemicIndex,
  input  logic       fallClear,
  output logic [3:0] alarm,
  output logic [3:0] glycemicOut,
  output logic [3:0] sensorFault,
  output logic       scanDone,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, REQ, SETTLE, CAPTURE, NEXT} stateT;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] REQ_LAST    = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] ALARM_MAX   = 4'(ALARM_COUNT);

  stateT      state, nextState;
  logic [1:0] channel;
  logic [3:0] settleCnt;
  logic [7:0] reqCnt;
  logic [3:0] debounceCnt [4];
  logic [3:0] resultBits;
  logic       curResult;
  logic       ackTimeout;

`ifndef FALL_LATCH_EN
  logic unusedFallClear;
  assign unusedFallClear = fallClear;
`endif

  assign resultBits = {temperatureAbnormality, fallDetected, bloodAbnormality, presureAbnormality};
  assign curResult  = resultBits[channel];
  assign ackTimeout = (state == REQ) && !sensorAck && (reqCnt == REQ_LAST);

  assign sensorReq = (state == REQ);
  assign sensorSel = channel;
  assign scanDone  = (state == NEXT) && (channel == 2'd3);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode; a scan in progress always finishes before returning to IDLE
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (scanEnable) nextState = REQ;
      REQ: begin
        if (sensorAck)       nextState = SETTLE;
        else if (ackTimeout) nextState = NEXT;
      end
      SETTLE:  if (settleCnt <= 4'd1) nextState = CAPTURE;
      CAPTURE: nextState = NEXT;
      NEXT: begin
        if ((channel == 2'd3) && !scanEnable) nextState = IDLE;
        else                                  nextState = REQ;
      end
      default: nextState = IDLE;
    endcase
  end

  // Channel pointer, settle countdown and ack-timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      channel   <= 2'd0;
      settleCnt <= 4'd0;
      reqCnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          channel <= 2'd0;
          reqCnt  <= 8'd0;
        end
        REQ: begin
          if (sensorAck) begin
            settleCnt <= SETTLE_LOAD;
            reqCnt    <= 8'd0;
          end else if (ackTimeout) begin
            reqCnt <= 8'd0;
          end else begin
            reqCnt <= reqCnt + 8'd1;
          end
        end
        SETTLE: settleCnt <= settleCnt - 4'd1;
        NEXT:   channel   <= channel + 2'd1;
        default: ;
      endcase
    end
  end

  // Fault flags, debounce counters, alarms and the glycemic capture register
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm       <= 4'd0;
      sensorFault <= 4'd0;
      glycemicOut <= 4'd0;
      for (int i = 0; i < 4; i++) debounceCnt[i] <= 4'd0;
    end else begin
      if (state == REQ) begin
        if (sensorAck)       sensorFault[channel] <= 1'b0;
        else if (ackTimeout) sensorFault[channel] <= 1'b1;
      end
      if (state == CAPTURE) begin
        if (curResult) begin
          if (debounceCnt[channel] < ALARM_MAX)
            debounceCnt[channel] <= debounceCnt[channel] + 4'd1;
          if (debounceCnt[channel] >= (ALARM_MAX - 4'd1))
            alarm[channel] <= 1'b1;
        end else begin
`ifdef FALL_LATCH_EN
          if (!((channel == 2'd2) && alarm[2])) begin
            debounceCnt[channel] <= 4'd0;
            alarm[channel]       <= 1'b0;
          end
`else
          debounceCnt[channel] <= 4'd0;
          alarm[channel]       <= 1'b0;
`endif
        end
        if (channel == 2'd1) glycemicOut <= glycemicIndex;
      end
`ifdef FALL_LATCH_EN
      if (fallClear) begin
        debounceCnt[2] <= 4'd0;
        alarm[2]       <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_hcs_scan_controller.sv
// tb_hcs_scan_controller: directed bench for hcs_scan_controller with default
// parameters. Inputs change and outputs are sampled on the falling clock edge.
module tb_hcs_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       scanEnable;
  logic [1:0] sensorSel;
  logic       sensorReq;
  logic       sensorAck;
  logic       presureAbnormality;
  logic       bloodAbnormality;
  logic       fallDetected;
  logic       temperatureAbnormality;
  logic [3:0] glycemicIndex;
  logic       fallClear;
  logic [3:0] alarm;
  logic [3:0] glycemicOut;
  logic [3:0] sensorFault;
  logic       scanDone;
  logic       busy;

  int         compared = 0;
  int         mismatched = 0;
  logic       ackOn = 1'b0;
  logic       blockCh2 = 1'b0;
  logic       prevReq = 1'b0;
  logic [7:0] selSeq;
  int         scanLen;

  hcs_scan_controller dut (
    .clk(clk), .reset(reset), .scanEnable(scanEnable),
    .sensorSel(sensorSel), .sensorReq(sensorReq), .sensorAck(sensorAck),
    .presureAbnormality(presureAbnormality), .bloodAbnormality(bloodAbnormality),
    .fallDetected(fallDetected), .temperatureAbnormality(temperatureAbnormality),
    .glycemicIndex(glycemicIndex), .fallClear(fallClear),
    .alarm(alarm), .glycemicOut(glycemicOut), .sensorFault(sensorFault),
    .scanDone(scanDone), .busy(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic b, input logic f, input logic t);
    presureAbnormality     = p;
    bloodAbnormality       = b;
    fallDetected           = f;
    temperatureAbnormality = t;
  endtask

  // Advance to the next falling edge and update the front-end ack model
  task automatic tick(output logic reqRise);
    @(negedge clk);
    sensorAck = ackOn && !(blockCh2 && (sensorSel == 2'd2));
    reqRise = sensorReq && !prevReq;
    prevReq = sensorReq;
  endtask

  task automatic nextScanDone(output int cycles);
    logic rise;
    cycles = 0;
    selSeq = 8'd0;
    do begin
      tick(rise);
      cycles++;
      if (rise) selSeq = {selSeq[5:0], sensorSel};
    end while (!scanDone && cycles < 100);
    if (!scanDone) checkOutput("scanDoneSeen", 32'd0, 32'd1);
  endtask

  task automatic waitSel(input logic [1:0] ch);
    logic rise;
    int n = 0;
    do begin
      tick(rise);
      n++;
    end while (!(sensorReq && sensorSel == ch) && n < 100);
    if (!(sensorReq && sensorSel == ch)) checkOutput("waitSelSeen", 32'd0, 32'd1);
  endtask

  initial begin
    logic rise;
    reset = 1'b1; scanEnable = 1'b0; sensorAck = 1'b0;
    glycemicIndex = 4'h0; fallClear = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    tick(rise); tick(rise);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstReq", sensorReq, 1'b0);
    checkOutput("rstAlarm", alarm, 4'h0);
    checkOutput("rstFault", sensorFault, 4'h0);
    checkOutput("rstGlyc", glycemicOut, 4'h0);
    checkOutput("rstDone", scanDone, 1'b0);

    // Clean scans: 20 cycles each, channels 0..3 in order
    reset = 1'b0; scanEnable = 1'b1; ackOn = 1'b1; sensorAck = 1'b1;
    nextScanDone(scanLen);
    checkOutput("scan1Len", scanLen, 20);
    checkOutput("scan1Seq", selSeq, 8'h1B);
    checkOutput("scan1Alarm", alarm, 4'h0);
    checkOutput("scan1Fault", sensorFault, 4'h0);
    tick(rise);
    checkOutput("donePulse", scanDone, 1'b0);
    nextScanDone(scanLen);
    checkOutput("scan2Len", scanLen, 19);

    // Glycemic capture on the blood channel only
    glycemicIndex = 4'hA;
    waitSel(2'd2);
    glycemicIndex = 4'h3;
    nextScanDone(scanLen);
    checkOutput("glycA", glycemicOut, 4'hA);
    waitSel(2'd1);
    checkOutput("glycHold", glycemicOut, 4'hA);
    nextScanDone(scanLen);
    checkOutput("glyc3", glycemicOut, 4'h3);

    // Pressure debounce: alarm after third capture, clears on first normal one
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextScanDone(scanLen);
    checkOutput("pres1", alarm, 4'h0);
    nextScanDone(scanLen);
    checkOutput("pres2", alarm, 4'h0);
    nextScanDone(scanLen);
    checkOutput("pres3", alarm, 4'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextScanDone(scanLen);
    checkOutput("presClr", alarm, 4'h0);

    // Fall alarm, then an ack timeout on channel 2
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    nextScanDone(scanLen);
    checkOutput("fall1", alarm, 4'h0);
    nextScanDone(scanLen);
    checkOutput("fall2", alarm, 4'h0);
    nextScanDone(scanLen);
    checkOutput("fall3", alarm, 4'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    blockCh2 = 1'b1;
    nextScanDone(scanLen);
    checkOutput("toLen", scanLen, 32);
    checkOutput("toFault", sensorFault, 4'h4);
    checkOutput("toAlarm", alarm, 4'h4);
    blockCh2 = 1'b0;
    nextScanDone(scanLen);
    checkOutput("ackLen", scanLen, 20);
    checkOutput("ackFault", sensorFault, 4'h0);
`ifdef FALL_LATCH_EN
    checkOutput("fallSticky", alarm, 4'h4);
`else
    checkOutput("fallNormal", alarm, 4'h0);
`endif
    fallClear = 1'b1;
    tick(rise);
    fallClear = 1'b0;
    nextScanDone(scanLen);
    checkOutput("fallCleared", alarm, 4'h0);

    // Reset during channel-1 settle with an active pressure alarm
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextScanDone(scanLen);
    nextScanDone(scanLen);
    nextScanDone(scanLen);
    checkOutput("pres3b", alarm, 4'h1);
    waitSel(2'd1);
    tick(rise);
    checkOutput("settleReq", sensorReq, 1'b0);
    reset = 1'b1;
    tick(rise);
    checkOutput("midRstAlarm", alarm, 4'h0);
    checkOutput("midRstGlyc", glycemicOut, 4'h0);
    checkOutput("midRstFault", sensorFault, 4'h0);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstReq", sensorReq, 1'b0);
    checkOutput("midRstSel", sensorSel, 2'd0);
    reset = 1'b0;
    tick(rise);
    checkOutput("restartReq", sensorReq, 1'b1);
    checkOutput("restartSel", sensorSel, 2'd0);
    nextScanDone(scanLen);
    checkOutput("restartLen", scanLen, 19);
    checkOutput("restartAlarm", alarm, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
